// File: rtl/dwc_retry_ctrl.sv
// Retry sequencer for a duplication-with-comparison protected unit.
// Re-executes on mismatch, returns the result, and locks on exhaustion.
module dwc_retry_ctrl #(
  parameter int   WIDTH      = 1,
  parameter int   LATENCY    = 1,
  parameter int   MAX_RETRY  = 2,
  parameter int   CNT_W      = 8,
  parameter logic ERR_ACTIVE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             port_req_valid,
  output logic             port_req_ready,
  input  logic [WIDTH-1:0] port_req_a,
  input  logic [WIDTH-1:0] port_req_b,
  output logic [WIDTH-1:0] port_op_a,
  output logic [WIDTH-1:0] port_op_b,
  input  logic [WIDTH-1:0] port_dwc_out,
  input  logic             port_dwc_error,
  output logic             port_rsp_valid,
  input  logic             port_rsp_ready,
  output logic [WIDTH-1:0] port_rsp_data,
  output logic             port_rsp_err,
  output logic             port_rsp_retried,
  output logic             port_fatal,
  output logic [CNT_W-1:0] port_err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_EVAL,
    S_RESP,
    S_LOCK
  } state_t;

  localparam logic [3:0] WLOAD = 4'(LATENCY - 1);
  localparam logic [2:0] RMAX  = 3'(MAX_RETRY);
  localparam logic       RTRY  = (MAX_RETRY > 0);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t           state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [2:0]       rcnt_q, rcnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic             rtry_q, rtry_d;
  logic             fatal_q, fatal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             mismatch;

  assign mismatch = (port_dwc_error == ERR_ACTIVE);
  // Saturating: the count never wraps back to zero.
  assign cnt_inc  = (cnt_q == CMAX) ? cnt_q
                                    : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    data_d  = data_q;
    err_d   = err_q;
    rtry_d  = rtry_q;
    fatal_d = fatal_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (port_req_valid) begin
          op_a_d  = port_req_a;
          op_b_d  = port_req_b;
          rcnt_d  = '0;
          wcnt_d  = WLOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = S_EVAL;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_EVAL: begin
        if (!mismatch) begin
          data_d  = port_dwc_out;
          err_d   = 1'b0;
          rtry_d  = (rcnt_q != 3'd0);
          state_d = S_RESP;
        end else if (rcnt_q < RMAX) begin
          rcnt_d  = rcnt_q + 3'd1;
          cnt_d   = cnt_inc;
          wcnt_d  = WLOAD;
          state_d = S_WAIT;
        end else begin
          cnt_d   = cnt_inc;
          fatal_d = 1'b1;
          data_d  = port_dwc_out;
          err_d   = 1'b1;
          rtry_d  = RTRY;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (port_rsp_ready) begin
          state_d = fatal_q ? S_LOCK : S_IDLE;
        end
      end
      S_LOCK:  state_d = S_LOCK;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      rtry_q  <= 1'b0;
      fatal_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      data_q  <= data_d;
      err_q   <= err_d;
      rtry_q  <= rtry_d;
      fatal_q <= fatal_d;
      cnt_q   <= cnt_d;
    end
  end

  assign port_req_ready   = (state_q == S_IDLE);
  assign port_rsp_valid   = (state_q == S_RESP);
  assign port_op_a        = op_a_q;
  assign port_op_b        = op_b_q;
  assign port_rsp_data    = data_q;
  assign port_rsp_err     = err_q;
  assign port_rsp_retried = rtry_q;
  assign port_fatal       = fatal_q;
  assign port_err_count   = cnt_q;

endmodule

// File: tb/tb_dwc_retry_ctrl.sv
// Randomized bench for dwc_retry_ctrl against a per-operation
// model: counts of evaluations, mismatches and response timing.
module tb_dwc_retry_ctrl;

  localparam int LAT  = 1;
  localparam int MAXR = 2;
  localparam int CW   = 8;
  localparam int CSAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [0:0]    req_a, req_b;
  logic [0:0]    op_a, op_b;
  logic [0:0]    dwc_out;
  logic          dwc_error;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [0:0]    rsp_data;
  logic          rsp_err;
  logic          rsp_retried;
  logic          fatal;
  logic [CW-1:0] err_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;
  int exp_fatal = 0;

  always #5 clk = ~clk;

  dwc_retry_ctrl #(
    .WIDTH(1), .LATENCY(LAT), .MAX_RETRY(MAXR),
    .CNT_W(CW), .ERR_ACTIVE(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .port_req_valid(req_valid),
    .port_req_ready(req_ready),
    .port_req_a(req_a),
    .port_req_b(req_b),
    .port_op_a(op_a),
    .port_op_b(op_b),
    .port_dwc_out(dwc_out),
    .port_dwc_error(dwc_error),
    .port_rsp_valid(rsp_valid),
    .port_rsp_ready(rsp_ready),
    .port_rsp_data(rsp_data),
    .port_rsp_err(rsp_err),
    .port_rsp_retried(rsp_retried),
    .port_fatal(fatal),
    .port_err_count(err_count)
  );

  task automatic chk(input string tag,
                     input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic check_reset();
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_op_a", int'(op_a), 0);
    chk("rst_op_b", int'(op_b), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    chk("rst_retried", int'(rsp_retried), 0);
    chk("rst_fatal", int'(fatal), 0);
    chk("rst_count", int'(err_count), 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    exp_fatal = 0;
  endtask

  // nerr: how many leading evaluations see a mismatch.
  task automatic do_op(input logic a, input logic b,
                       input int nerr, input int hold);
    int evals, mis, t_rsp, e_data, e_rtry;
    evals = (nerr > MAXR) ? MAXR + 1 : nerr + 1;
    mis   = (nerr > MAXR) ? MAXR + 1 : nerr;
    t_rsp = (LAT + 1) * evals + 1;
    e_data = int'(a & b);
    @(negedge clk);
    chk("req_ready_idle", int'(req_ready), 1);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a = 1'($urandom);
    req_b = 1'($urandom);
    for (int t = 1; t < t_rsp; t++) begin
      if (t % (LAT + 1) == 0) begin
        dwc_out   = a & b;
        dwc_error = (t / (LAT + 1) <= nerr);
      end else begin
        dwc_out   = 1'($urandom);
        dwc_error = 1'($urandom);
      end
      rsp_ready = 1'($urandom);
      req_valid = 1'($urandom);
      @(negedge clk);
      chk("busy_rsp_valid", int'(rsp_valid), 0);
      chk("busy_req_ready", int'(req_ready), 0);
      chk("op_a_held", int'(op_a), int'(a));
      chk("op_b_held", int'(op_b), int'(b));
      chk("busy_fatal", int'(fatal), exp_fatal);
      @(posedge clk);
      #1;
    end
    exp_cnt = (exp_cnt + mis > CSAT) ? CSAT : exp_cnt + mis;
    if (nerr > MAXR) exp_fatal = 1;
    e_rtry = exp_fatal ? int'(MAXR > 0) : int'(nerr > 0);
    dwc_out   = 1'($urandom);
    dwc_error = 1'($urandom);
    for (int h = 0; h <= hold; h++) begin
      rsp_ready = (h == hold);
      req_valid = (h != hold);
      @(negedge clk);
      chk("rsp_valid", int'(rsp_valid), 1);
      chk("rsp_data", int'(rsp_data), e_data);
      chk("rsp_err", int'(rsp_err), exp_fatal);
      chk("rsp_retried", int'(rsp_retried), e_rtry);
      chk("rsp_fatal", int'(fatal), exp_fatal);
      chk("err_count", int'(err_count), exp_cnt);
      chk("rsp_req_ready", int'(req_ready), 0);
      @(posedge clk);
      #1;
      dwc_out   = 1'($urandom);
      dwc_error = 1'($urandom);
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("post_rsp_valid", int'(rsp_valid), 0);
    chk("post_req_ready", int'(req_ready), 1 - exp_fatal);
  endtask

  task automatic check_lock(input int n);
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("lock_req_ready", int'(req_ready), 0);
      chk("lock_rsp_valid", int'(rsp_valid), 0);
      chk("lock_fatal", int'(fatal), 1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    dwc_out = '0;
    dwc_error = 1'b0;
    rsp_ready = 1'b0;
    #3 check_reset();
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b1, 1'b1, 0, 0);
    do_op(1'b1, 1'b0, 1, 0);
    do_op(1'($urandom), 1'($urandom), 0, 10);
    for (int i = 0; i < 40; i++) begin
      do_op(1'($urandom), 1'($urandom),
            int'($urandom_range(0, MAXR)),
            int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 300; i++) begin
      do_op(1'($urandom), 1'($urandom), 1, 0);
    end
    chk("sat_count", int'(err_count), CSAT);
    chk("sat_fatal", int'(fatal), 0);

    do_op(1'($urandom), 1'($urandom), MAXR + 1, 2);
    check_lock(20);

    do_reset();
    do_op(1'b1, 1'b1, MAXR + 1, 0);
    chk("exh_count", int'(err_count), MAXR + 1);
    check_lock(20);

    do_reset();
    do_op(1'b0, 1'b1, 1, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_a = 1'b1;
    req_b = 1'b1;
    @(posedge clk);
    req_valid = 1'b0;
    do_reset();
    do_op(1'b1, 1'b1, 0, 0);
    chk("post_rst_count", int'(err_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
